// File: rtl/ed25519_pkg.sv
// Shared constants, state encoding and signature word selection for the Ed25519 signature packer.
package ed25519_pkg;

  localparam int SIG_WORDS = 16;

  // Group order L = 2^252 + 27742317777372353535851937790883648493
  localparam logic [252:0] L = 253'h1_00000000_00000000_00000000_0000000_14def9de_a2f79cd6_5812631a_5cf5d3ed;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_STREAM  = 1'b1
  } state_e;

  // Word idx of R||S, where byte 0 of R occupies the top of the concatenation.
  function automatic logic [31:0] sig_word(input logic [255:0] r, input logic [255:0] s,
                                           input logic [3:0] idx);
    logic [511:0] cat;
    cat = {r, s} << {idx, 5'd0};
    return cat[511:480];
  endfunction

endpackage

// File: rtl/ed25519_scalar_ge_l.sv
// Combinational check that an encoded little-endian scalar is not below the group order L.
module ed25519_scalar_ge_l
  import ed25519_pkg::*;
(
  input  logic [255:0] s_enc_i,
  output logic         ge_o
);

  logic [255:0] s_int;

  // Encoding byte 0 sits at [255:248] and is the least significant scalar byte.
  always_comb begin
    s_int = '0;
    for (int i = 0; i < 32; i++) begin
      s_int[8*i +: 8] = s_enc_i[255-8*i -: 8];
    end
  end

  assign ge_o = (s_int >= {3'b000, L});

endmodule

// File: rtl/ed25519_sig_packer.sv
// Collects encoded R and S, then streams the 64-byte signature as sixteen 32-bit words.
module ed25519_sig_packer
  import ed25519_pkg::*;
#(
  parameter bit CHECK_S = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         r_valid,
  input  logic [255:0] r_enc,
  input  logic         s_valid,
  input  logic [255:0] s_in,
  output logic         in_ready,
  output logic [31:0]  sig_tdata,
  output logic         sig_tvalid,
  input  logic         sig_tready,
  output logic         sig_tlast,
  output logic         sig_bad,
  output logic         drop_err,
  output state_e       dbg_state
);

  // Output handshake: a beat transfers on a rising edge where sig_tvalid && sig_tready;
  // while sig_tvalid && !sig_tready, sig_tdata/sig_tlast hold their values.

  localparam logic [3:0] LAST_IDX = 4'(SIG_WORDS - 1);

  state_e       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic         have_r_q, have_r_d;
  logic         have_s_q, have_s_d;
  logic [255:0] r_q, r_d;
  logic [255:0] s_q, s_d;
  logic [31:0]  tdata_q, tdata_d;
  logic         tvalid_q, tvalid_d;
  logic         tlast_q, tlast_d;
  logic         bad_q, bad_d;
  logic         drop_q, drop_d;
  logic         s_ge;

  ed25519_scalar_ge_l u_ge (
    .s_enc_i (s_in),
    .ge_o    (s_ge)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    have_r_d = have_r_q;
    have_s_d = have_s_q;
    r_d      = r_q;
    s_d      = s_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    bad_d    = bad_q;
    drop_d   = drop_q;

    if (clr) begin
      state_d  = ST_COLLECT;
      idx_d    = '0;
      have_r_d = 1'b0;
      have_s_d = 1'b0;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      bad_d    = 1'b0;
      drop_d   = 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (r_valid) begin
            r_d      = r_enc;
            have_r_d = 1'b1;
          end
          if (s_valid) begin
            s_d      = s_in;
            have_s_d = 1'b1;
            bad_d    = CHECK_S ? s_ge : 1'b0;
          end
          // Operands completing on this edge go straight to word 0.
          if (have_r_d && have_s_d) begin
            state_d  = ST_STREAM;
            idx_d    = '0;
            tvalid_d = 1'b1;
            tlast_d  = 1'b0;
            tdata_d  = sig_word(r_d, s_d, 4'd0);
          end
        end
        ST_STREAM: begin
          if (r_valid || s_valid) drop_d = 1'b1;
          if (tvalid_q && sig_tready) begin
            if (idx_q == LAST_IDX) begin
              state_d  = ST_COLLECT;
              idx_d    = '0;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              have_r_d = 1'b0;
              have_s_d = 1'b0;
            end else begin
              idx_d   = idx_q + 4'd1;
              tdata_d = sig_word(r_q, s_q, idx_d);
              tlast_d = (idx_d == LAST_IDX);
            end
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_COLLECT;
      idx_q    <= '0;
      have_r_q <= 1'b0;
      have_s_q <= 1'b0;
      r_q      <= '0;
      s_q      <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      bad_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      have_r_q <= have_r_d;
      have_s_q <= have_s_d;
      r_q      <= r_d;
      s_q      <= s_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      bad_q    <= bad_d;
      drop_q   <= drop_d;
    end
  end

  assign in_ready   = (state_q == ST_COLLECT);
  assign sig_tdata  = tdata_q;
  assign sig_tvalid = tvalid_q;
  assign sig_tlast  = tlast_q;
  assign sig_bad    = bad_q;
  assign drop_err   = drop_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ed25519_sig_packer.sv
// Directed bench for ed25519_sig_packer with a byte-level signature model checked every cycle.
module tb_ed25519_sig_packer;
  import ed25519_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         r_valid;
  logic [255:0] r_enc;
  logic         s_valid;
  logic [255:0] s_in;
  logic         in_ready;
  logic [31:0]  sig_tdata;
  logic         sig_tvalid;
  logic         sig_tready;
  logic         sig_tlast;
  logic         sig_bad;
  logic         drop_err;
  state_e       dbg_state;

  ed25519_sig_packer #(.CHECK_S(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .r_valid    (r_valid),
    .r_enc      (r_enc),
    .s_valid    (s_valid),
    .s_in       (s_in),
    .in_ready   (in_ready),
    .sig_tdata  (sig_tdata),
    .sig_tvalid (sig_tvalid),
    .sig_tready (sig_tready),
    .sig_tlast  (sig_tlast),
    .sig_bad    (sig_bad),
    .drop_err   (drop_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- model / scoreboard state ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [255:0] l_val;
  logic [31:0]  exp_q[$];
  bit           m_active, m_have_r, m_have_s, m_bad, m_drop;
  logic [255:0] m_r, m_s;
  bit           stall_mode;
  bit           pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int           cyc;
  bit           prev_active, prev_ready;
  logic [31:0]  prev_data;
  int           dut_beats;
  logic         dut_bad_first;

  function automatic logic [255:0] rev_bytes(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = v[255-8*i -: 8];
    return r;
  endfunction

  function automatic bit model_ge(input logic [255:0] s_enc);
    return rev_bytes(s_enc) >= l_val;
  endfunction

  function automatic logic [31:0] model_word(input logic [255:0] r, input logic [255:0] s,
                                             input int k);
    logic [7:0] b[64];
    for (int j = 0; j < 32; j++) begin
      b[j]      = r[255-8*j -: 8];
      b[32 + j] = s[255-8*j -: 8];
    end
    return {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_have_r = 0; m_have_s = 0; m_bad = 0; m_drop = 0;
    exp_q.delete();
    prev_active = 0;
  endtask

  // Advance the model by one rising edge using the inputs as driven.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (clr) begin
      m_active = 0; m_have_r = 0; m_have_s = 0; m_bad = 0; m_drop = 0;
      exp_q.delete();
    end else if (!m_active) begin
      if (r_valid) begin m_r = r_enc; m_have_r = 1; end
      if (s_valid) begin m_s = s_in; m_have_s = 1; m_bad = model_ge(s_in); end
      if (m_have_r && m_have_s) begin
        for (int k = 0; k < 16; k++) exp_q.push_back(model_word(m_r, m_s, k));
        m_active = 1;
      end
    end else begin
      if (r_valid || s_valid) m_drop = 1;
      if (sig_tready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_active = 0; m_have_r = 0; m_have_s = 0;
        end
      end
    end
  endtask

  task automatic compare();
    @(negedge clk);
    check("tvalid", sig_tvalid, m_active);
    check("in_ready", in_ready, !m_active);
    check("drop_err", drop_err, m_drop);
    check("state", dbg_state, m_active ? ST_STREAM : ST_COLLECT);
    if (m_active) begin
      check("tdata", sig_tdata, exp_q[0]);
      check("tlast", sig_tlast, exp_q.size() == 1);
      check("sig_bad", sig_bad, m_bad);
      if (prev_active && !prev_ready) check("hold", sig_tdata, prev_data);
    end
    if (sig_tvalid && dut_beats == 0) dut_bad_first = sig_bad;
    if (sig_tvalid && sig_tready) dut_beats++;
    prev_active = m_active;
    prev_ready  = sig_tready;
    prev_data   = sig_tdata;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    compare();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    sig_tready = stall_mode ? pat[cyc % 4] : 1'b1;
  endtask

  task automatic send_pair(input logic [255:0] r, input logic [255:0] s, input int gap);
    dut_beats = 0;
    r_enc = r; r_valid = 1'b1;
    if (gap == 0) begin s_in = s; s_valid = 1'b1; end
    tick();
    r_valid = 1'b0; s_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap - 1) tick();
      s_in = s; s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
    end
  endtask

  task automatic run_out(input string name);
    for (int n = 0; n < 200 && m_active; n++) tick();
    check({name, "_done"}, m_active, 1'b0);
    check({name, "_beats"}, dut_beats, 16);
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] s_aa, s7, s_l, s_lm1, r_rnd;

  initial begin
    l_val = (256'd1 << 252) + 256'd27742317777372353535851937790883648493;
    s_aa  = {32{8'hAA}};
    s7    = rev_bytes(256'd7);
    s_l   = rev_bytes(l_val);
    s_lm1 = rev_bytes(l_val - 256'd1);
    rst_n = 1'b0; clr = 1'b0; r_valid = 1'b0; s_valid = 1'b0;
    r_enc = '0; s_in = '0; sig_tready = 1'b1; stall_mode = 0; cyc = 0;
    dut_beats = 0; dut_bad_first = 1'b0;
    model_reset();

    // Literal pins on the model itself.
    check("pin_w0", model_word(256'h1FF, s_aa, 0), 32'h0000_0000);
    check("pin_w7", model_word(256'h1FF, s_aa, 7), 32'h0000_01FF);
    check("pin_w8", model_word(256'h1FF, s_aa, 8), 32'hAAAA_AAAA);
    check("pin_l_top", l_val[255:224], 32'h1000_0000);
    check("pin_l_low", l_val[31:0], 32'h5cf5_d3ed);
    check("pin_ge_aa", model_ge(s_aa), 1'b1);
    check("pin_ge_l", model_ge(s_l), 1'b1);
    check("pin_ge_lm1", model_ge(s_lm1), 1'b0);
    check("pin_ge_7", model_ge(s7), 1'b0);

    // Reset values, observed while reset is held.
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_tvalid", sig_tvalid, 1'b0);
    check("rst_tdata", sig_tdata, 32'h0);
    check("rst_tlast", sig_tlast, 1'b0);
    check("rst_bad", sig_bad, 1'b0);
    check("rst_drop", drop_err, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // R then S two cycles later; S = 0xAA.. exceeds L.
    send_pair(256'h1FF, s_aa, 2);
    run_out("t1");
    check("t1_bad", dut_bad_first, 1'b1);

    // Same-cycle R and S, small S.
    send_pair(256'h0123_4567_89ab_cdef, s7, 0);
    run_out("t2");
    check("t2_bad", dut_bad_first, 1'b0);

    // Range boundary.
    send_pair({8{32'hdead_beef}}, s_l, 1);
    run_out("t3a");
    check("t3a_bad", dut_bad_first, 1'b1);
    send_pair({8{32'h5a5a_0f0f}}, s_lm1, 0);
    run_out("t3b");
    check("t3b_bad", dut_bad_first, 1'b0);

    // Back-pressure plus a dropped mid-stream R pulse.
    stall_mode = 1;
    r_rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_pair(r_rnd, s7, 1);
    repeat (5) tick();
    r_enc = ~r_rnd; r_valid = 1'b1;
    tick();
    r_valid = 1'b0;
    run_out("t4");
    check("t4_drop", drop_err, 1'b1);
    stall_mode = 0; sig_tready = 1'b1;
    clr = 1'b1; tick(); clr = 1'b0;
    check("t4_drop_clr", drop_err, 1'b0);

    // clr discards a same-cycle capture.
    s_in = s_aa; s_valid = 1'b1; tick(); s_valid = 1'b0;
    clr = 1'b1; r_enc = 256'h55; r_valid = 1'b1; tick(); clr = 1'b0; r_valid = 1'b0;
    r_enc = 256'h66; r_valid = 1'b1; tick(); r_valid = 1'b0;
    repeat (3) tick();
    check("t5_no_stream", sig_tvalid, 1'b0);
    clr = 1'b1; tick(); clr = 1'b0;

    // clr at beat 5, then a fresh pair.
    send_pair({8{32'h1111_2222}}, s7, 0);
    for (int n = 0; n < 100 && dut_beats < 5; n++) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("t6_clr_tvalid", sig_tvalid, 1'b0);
    tick();
    send_pair({8{32'h3333_4444}}, s_lm1, 1);
    run_out("t6");
    check("t6_drop", drop_err, 1'b0);

    // Asynchronous reset at beat 9, then a fresh pair.
    send_pair({8{32'h7777_8888}}, s_aa, 0);
    for (int n = 0; n < 100 && dut_beats < 9; n++) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t7_rst_tvalid", sig_tvalid, 1'b0);
    check("t7_rst_in_ready", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    send_pair({8{32'h9999_aaaa}}, s7, 2);
    run_out("t7");
    check("t7_drop", drop_err, 1'b0);
    check("t7_bad", dut_bad_first, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
